// File: rtl/set_host_driver_if.sv
// set_host_driver_if: job, SET engine and result signals of set_host_driver.
// master = the driver itself, slave = job source / SET engine / result consumer.
interface set_host_driver_if;
    // job source side
    logic        job_valid;
    logic        job_ready;
    logic [23:0] job_central;
    logic [11:0] job_radius;
    logic [1:0]  job_mode;
    // SET engine side
    logic        en;
    logic [23:0] central;
    logic [11:0] radius;
    logic [1:0]  mode;
    logic        busy;
    logic        valid;
    logic [7:0]  candidate;
    // result side
    logic        res_valid;
    logic        res_ready;
    logic [7:0]  res_data;
    logic [1:0]  res_mode;
    logic        timeout_err;

    modport master (
        input  job_valid, job_central, job_radius, job_mode,
        input  busy, valid, candidate, res_ready,
        output job_ready, en, central, radius, mode,
        output res_valid, res_data, res_mode, timeout_err
    );

    modport slave (
        output job_valid, job_central, job_radius, job_mode,
        output busy, valid, candidate, res_ready,
        input  job_ready, en, central, radius, mode,
        input  res_valid, res_data, res_mode, timeout_err
    );
endinterface

// File: rtl/set_host_driver.sv
// set_host_driver: buffers SET jobs in a FIFO, issues each with a one-cycle
// en pulse, waits for the engine's valid strobe and returns the candidate.
// Ports: clk; rst (async, active low); bus (set_host_driver_if.master):
//   job_valid/job_ready/job_central/job_radius/job_mode  job push side
//   en/central/radius/mode/busy/valid/candidate          SET engine side
//   res_valid/res_ready/res_data/res_mode                result handshake
//   timeout_err                                          aborted-job pulse
// Optional feature macro: SET_HOST_TIMEOUT_EN (abort after TIMEOUT WAIT cycles).
module set_host_driver #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 2047
) (
    input  logic              clk,
    input  logic              rst,
    set_host_driver_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int JW = 38;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESULT
    } state_t;

    generate
        if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TIMEOUT < 1)) begin : g_bad_param
            $error("set_host_driver: bad DEPTH/TIMEOUT");
        end
    endgenerate

    // job FIFO
    logic [JW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [JW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // FSM and datapath
    state_t      state_q;
    state_t      state_d;
    logic        load_res;
    logic        res_done;
    logic        expired;
    logic        timeout_hit;
    logic [23:0] central_q;
    logic [11:0] radius_q;
    logic [1:0]  mode_q;
    logic        res_valid_q;
    logic [7:0]  res_data_q;
    logic [1:0]  res_mode_q;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    // a full FIFO refuses the push even if the head leaves on the same edge
    assign push  = bus.job_valid & ~full;
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.job_central, bus.job_radius, bus.job_mode};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef SET_HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    logic [TW-1:0] wait_cnt;

    // cleared while in ISSUE so it reads 0 on the first WAIT cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
        end else if (state_q == ISSUE) begin
            wait_cnt <= '0;
        end else if ((state_q == WAIT) && (wait_cnt != TMAX)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign expired = (wait_cnt == TMAX);
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pop         = 1'b0;
        load_res    = 1'b0;
        res_done    = 1'b0;
        timeout_hit = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty && !bus.busy) begin
                    state_d = ISSUE;
                    pop     = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                // a result arriving on the expiry cycle still wins
                if (bus.valid) begin
                    state_d  = RESULT;
                    load_res = 1'b1;
                end else if (expired) begin
                    state_d     = IDLE;
                    timeout_hit = 1'b1;
                end
            end
            RESULT: begin
                if (bus.res_ready) begin
                    state_d  = IDLE;
                    res_done = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // job fields are held from issue until the next issue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= '0;
        end else if (pop) begin
            {central_q, radius_q, mode_q} <= head;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_mode_q  <= '0;
        end else if (load_res) begin
            res_valid_q <= 1'b1;
            res_data_q  <= bus.candidate;
            res_mode_q  <= mode_q;
        end else if (res_done) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.job_ready   = ~full;
    assign bus.en          = (state_q == ISSUE);
    assign bus.central     = central_q;
    assign bus.radius      = radius_q;
    assign bus.mode        = mode_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_mode    = res_mode_q;
    assign bus.timeout_err = timeout_hit;
endmodule
